// File: rtl/ctrl_pkg.sv
// Shared encodings and pipeline-register layouts for the pipelined ARM control unit.
package ctrl_pkg;

  typedef enum logic [1:0] {
    OP_DP   = 2'b00,
    OP_MEM  = 2'b01,
    OP_BR   = 2'b10,
    OP_NONE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_e;

  typedef enum logic [3:0] {
    CMD_AND = 4'b0000,
    CMD_SUB = 4'b0010,
    CMD_ADD = 4'b0100,
    CMD_CMP = 4'b1010,
    CMD_ORR = 4'b1100
  } cmd_e;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  // Execute-stage control word; an all-zero value is a harmless bubble.
  typedef struct packed {
    logic      pcsrc;
    logic      regwrite;
    logic      memwrite;
    logic      memtoreg;
    logic      branch;
    logic      alusrc;
    alu_ctrl_e alu_ctrl;
    logic [1:0] flagw;
    cond_e     cond;
  } ctrl_e_t;

  typedef struct packed {
    logic regwrite;
    logic memwrite;
    logic memtoreg;
    logic pcsrc;
  } ctrl_m_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic pcsrc;
  } ctrl_w_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluation against the NZCV flags.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       CondEx
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    // NOTE: default first so every path assigns CondEx and no latch is inferred.
    CondEx = 1'b0;
    unique case (cond_e'(cond))
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipeline_controller.sv
// Decode/Execute/Memory/Writeback control pipeline with NZCV flags.
// Optional CTRL_CMP_EN adds CMP (cmd 1010) support.
module pipeline_controller
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] InstrD,
  input  logic [3:0]  ALUFlagsE,
  input  logic        FlushE,
  output logic [1:0]  RegSrcD,
  output logic [1:0]  ImmSrcD,
  output logic        ALUSrcE,
  output logic [1:0]  ALUControlE,
  output logic        BranchTakenE,
  output logic        MemtoRegE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        PCSrcW,
  output logic        PCWrPendingF
);

  // InstrD holds instruction bits [31:12].
  op_e        op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign op        = op_e'(InstrD[15:14]);
  assign funct     = InstrD[13:8];
  assign rd        = InstrD[3:0];
  assign unused_rn = ^InstrD[7:4];

  ctrl_e_t    ctrl_d, ctrl_e_d, ctrl_e_q;
  ctrl_m_t    ctrl_m_d, ctrl_m_q;
  ctrl_w_t    ctrl_w_d, ctrl_w_q;
  logic [3:0] flags_d, flags_q;
  logic       cond_ex;

  always_comb begin
    RegSrcD     = 2'b00;
    ImmSrcD     = 2'b00;
    ctrl_d      = '0;
    ctrl_d.cond = cond_e'(InstrD[19:16]);
    unique case (op)
      OP_DP: begin
        ctrl_d.alusrc   = funct[5];
        ctrl_d.regwrite = 1'b1;
        case (cmd_e'(funct[4:1]))
          CMD_ADD: begin ctrl_d.alu_ctrl = ALU_ADD; ctrl_d.flagw = {2{funct[0]}}; end
          CMD_SUB: begin ctrl_d.alu_ctrl = ALU_SUB; ctrl_d.flagw = {2{funct[0]}}; end
          CMD_AND: begin ctrl_d.alu_ctrl = ALU_AND; ctrl_d.flagw = {funct[0], 1'b0}; end
          CMD_ORR: begin ctrl_d.alu_ctrl = ALU_ORR; ctrl_d.flagw = {funct[0], 1'b0}; end
`ifdef CTRL_CMP_EN
          CMD_CMP: begin
            ctrl_d.alu_ctrl = ALU_SUB;
            ctrl_d.regwrite = 1'b0;
            ctrl_d.flagw    = {2{funct[0]}};
          end
`endif
          default: ctrl_d.regwrite = 1'b0;
        endcase
      end
      OP_MEM: begin
        ImmSrcD       = 2'b01;
        ctrl_d.alusrc = 1'b1;
        if (funct[0]) begin
          ctrl_d.memtoreg = 1'b1;
          ctrl_d.regwrite = 1'b1;
        end else begin
          RegSrcD         = 2'b10;
          ctrl_d.memwrite = 1'b1;
        end
      end
      OP_BR: begin
        RegSrcD       = 2'b01;
        ImmSrcD       = 2'b10;
        ctrl_d.alusrc = 1'b1;
        ctrl_d.branch = 1'b1;
      end
      default: ;
    endcase
    ctrl_d.pcsrc = ((rd == 4'd15) && ctrl_d.regwrite) || ctrl_d.branch;
  end

  cond_check u_cond_check (
    .cond   (ctrl_e_q.cond),
    .flags  (flags_q),
    .CondEx (cond_ex)
  );

  always_comb begin
    ctrl_e_d = FlushE ? ctrl_e_t'('0) : ctrl_d;

    ctrl_m_d.regwrite = ctrl_e_q.regwrite & cond_ex;
    ctrl_m_d.memwrite = ctrl_e_q.memwrite & cond_ex;
    ctrl_m_d.memtoreg = ctrl_e_q.memtoreg;
    ctrl_m_d.pcsrc    = ctrl_e_q.pcsrc & cond_ex;

    ctrl_w_d.regwrite = ctrl_m_q.regwrite;
    ctrl_w_d.memtoreg = ctrl_m_q.memtoreg;
    ctrl_w_d.pcsrc    = ctrl_m_q.pcsrc;

    // N,Z and C,V have independent write enables so logical ops keep carry/overflow.
    flags_d[3:2] = (ctrl_e_q.flagw[1] & cond_ex) ? ALUFlagsE[3:2] : flags_q[3:2];
    flags_d[1:0] = (ctrl_e_q.flagw[0] & cond_ex) ? ALUFlagsE[1:0] : flags_q[1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_e_q <= '0;
      ctrl_m_q <= '0;
      ctrl_w_q <= '0;
      flags_q  <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      ctrl_e_q <= ctrl_e_d;
      ctrl_m_q <= ctrl_m_d;
      ctrl_w_q <= ctrl_w_d;
      flags_q  <= flags_d;
    end
  end

  assign ALUSrcE      = ctrl_e_q.alusrc;
  assign ALUControlE  = ctrl_e_q.alu_ctrl;
  assign BranchTakenE = ctrl_e_q.branch & cond_ex;
  assign MemtoRegE    = ctrl_e_q.memtoreg;
  assign RegWriteM    = ctrl_m_q.regwrite;
  assign MemWriteM    = ctrl_m_q.memwrite;
  assign RegWriteW    = ctrl_w_q.regwrite;
  assign MemtoRegW    = ctrl_w_q.memtoreg;
  assign PCSrcW       = ctrl_w_q.pcsrc;
  assign PCWrPendingF = ctrl_d.pcsrc | ctrl_e_q.pcsrc | ctrl_m_q.pcsrc;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed self-checking bench for pipeline_controller (honours CTRL_CMP_EN).
module tb_pipeline_controller;

  logic        clk;
  logic        reset;
  logic [19:0] InstrD;
  logic [3:0]  ALUFlagsE;
  logic        FlushE;
  logic [1:0]  RegSrcD, ImmSrcD, ALUControlE;
  logic        ALUSrcE, BranchTakenE, MemtoRegE, RegWriteM, MemWriteM;
  logic        RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF;

  int checks   = 0;
  int failures = 0;

  // {cond, op, funct, Rn, Rd}
  localparam logic [19:0] I_NOP    = {4'hE, 2'b11, 6'b000000, 4'd0,  4'd0};
  localparam logic [19:0] I_ADDS   = {4'hE, 2'b00, 6'b001001, 4'd2,  4'd1};
  localparam logic [19:0] I_ADD    = {4'hE, 2'b00, 6'b001000, 4'd2,  4'd1};
  localparam logic [19:0] I_ANDS   = {4'hE, 2'b00, 6'b000001, 4'd2,  4'd1};
  localparam logic [19:0] I_ORRSI  = {4'hE, 2'b00, 6'b111001, 4'd2,  4'd1};
  localparam logic [19:0] I_CMP    = {4'hE, 2'b00, 6'b010101, 4'd1,  4'd0};
  localparam logic [19:0] I_ADDPC  = {4'hE, 2'b00, 6'b101000, 4'd15, 4'd15};
  localparam logic [19:0] I_LDR    = {4'hE, 2'b01, 6'b011001, 4'd5,  4'd4};
  localparam logic [19:0] I_STR    = {4'hE, 2'b01, 6'b011000, 4'd5,  4'd4};
  localparam logic [19:0] I_STR_NE = {4'h1, 2'b01, 6'b011000, 4'd5,  4'd4};
  localparam logic [19:0] I_BEQ    = {4'h0, 2'b10, 6'b100000, 4'd0,  4'd0};
  localparam logic [19:0] I_BCS    = {4'h2, 2'b10, 6'b100000, 4'd0,  4'd0};

`ifdef CTRL_CMP_EN
  localparam logic [1:0] CMP_ALU   = 2'b01;
  localparam logic       CMP_CSSET = 1'b1;
`else
  localparam logic [1:0] CMP_ALU   = 2'b00;
  localparam logic       CMP_CSSET = 1'b0;
`endif

  // Condition vectors: NZCV loaded by ADDS, branch cond, hand-derived taken result.
  logic [3:0] tbl_flags [16] = '{4'b1000, 4'b1000, 4'b0000, 4'b0100, 4'b0010, 4'b0110,
                                 4'b0001, 4'b0001, 4'b1001, 4'b0000, 4'b1000, 4'b1000,
                                 4'b0110, 4'b0000, 4'b0100, 4'b0000};
  logic [3:0] tbl_cond  [16] = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1000, 4'b1001,
                                 4'b0110, 4'b0111, 4'b1010, 4'b1111, 4'b0100, 4'b0101,
                                 4'b1000, 4'b0011, 4'b0001, 4'b1110};
  logic       tbl_taken [16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                 1'b0, 1'b1, 1'b0, 1'b1};

  pipeline_controller dut (
    .clk          (clk),
    .reset        (reset),
    .InstrD       (InstrD),
    .ALUFlagsE    (ALUFlagsE),
    .FlushE       (FlushE),
    .RegSrcD      (RegSrcD),
    .ImmSrcD      (ImmSrcD),
    .ALUSrcE      (ALUSrcE),
    .ALUControlE  (ALUControlE),
    .BranchTakenE (BranchTakenE),
    .MemtoRegE    (MemtoRegE),
    .RegWriteM    (RegWriteM),
    .MemWriteM    (MemWriteM),
    .RegWriteW    (RegWriteW),
    .MemtoRegW    (MemtoRegW),
    .PCSrcW       (PCSrcW),
    .PCWrPendingF (PCWrPendingF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] regd_outs();
    return {ALUSrcE, ALUControlE, BranchTakenE, MemtoRegE, RegWriteM,
            MemWriteM, RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF};
  endfunction

  initial begin
    reset     = 1'b0;
    InstrD    = I_NOP;
    ALUFlagsE = 4'b0000;
    FlushE    = 1'b0;
    step();
    step();
    check("reset_state", 16'(regd_outs()), 16'h0);
    reset = 1'b1;

    // ADDS sets Z, following BEQ sees it in its own Execute cycle.
    InstrD = I_ADDS;
    step();
    InstrD = I_BEQ; ALUFlagsE = 4'b0100;
    #1;
    check("adds_e", {ALUSrcE, ALUControlE, BranchTakenE}, 4'b0000);
    check("beq_d_src", {RegSrcD, ImmSrcD}, 4'b0110);
    step();
    InstrD = I_NOP; ALUFlagsE = 4'b0000;
    #1;
    check("beq_taken", BranchTakenE, 1'b1);
    check("adds_regw_m", RegWriteM, 1'b1);
    check("beq_pending", PCWrPendingF, 1'b1);
    step();
    step();

    // LDR latency through E/M/W.
    InstrD = I_LDR;
    #1;
    check("ldr_d_src", {RegSrcD, ImmSrcD}, 4'b0001);
    step();
    InstrD = I_NOP;
    check("ldr_e", {MemtoRegE, ALUSrcE, ALUControlE}, 4'b1100);
    step();
    step();
    check("ldr_w", {RegWriteW, MemtoRegW}, 2'b11);

    // STR under NE with Z=1 must not write; flags untouched.
    InstrD = I_STR_NE;
    #1;
    check("str_d_src", {RegSrcD, ImmSrcD}, 4'b1001);
    step();
    InstrD = I_BEQ; ALUFlagsE = 4'b1111;
    step();
    InstrD = I_STR; ALUFlagsE = 4'b0000;
    check("str_ne_memw_m", MemWriteM, 1'b0);
    check("str_ne_flags", BranchTakenE, 1'b1);
    step();
    InstrD = I_NOP;
    step();
    check("str_al_memw_m", MemWriteM, 1'b1);

    // ADD pc,pc,#4: pending for n..n+2, PCSrcW at n+3.
    check("pc_pre", PCWrPendingF, 1'b0);
    InstrD = I_ADDPC;
    #1;
    check("pc_n", PCWrPendingF, 1'b1);
    step();
    InstrD = I_NOP;
    #1;
    check("pc_n1", {PCWrPendingF, ALUSrcE}, 2'b11);
    step();
    check("pc_n2", PCWrPendingF, 1'b1);
    step();
    check("pc_n3", {PCWrPendingF, PCSrcW}, 2'b01);

    // Flushed ORRS: bubble in E, no register write, Z not cleared.
    InstrD = I_ORRSI; FlushE = 1'b1;
    step();
    FlushE = 1'b0; InstrD = I_BEQ; ALUFlagsE = 4'b0000;
    check("flush_e", {ALUSrcE, ALUControlE, MemtoRegE}, 4'b0000);
    step();
    InstrD = I_NOP;
    check("flush_regw_m", RegWriteM, 1'b0);
    check("flush_flags", BranchTakenE, 1'b1);

    // CMP with ALUFlagsE=0110: C becomes 1 only when CMP is supported.
    InstrD = I_CMP;
    step();
    InstrD = I_BCS; ALUFlagsE = 4'b0110;
    check("cmp_alu_e", ALUControlE, CMP_ALU);
    step();
    InstrD = I_NOP; ALUFlagsE = 4'b0000;
    check("cmp_regw_m", RegWriteM, 1'b0);
    check("cmp_flags", BranchTakenE, CMP_CSSET);

    // Condition table.
    for (int i = 0; i < 16; i++) begin
      InstrD = I_ADDS;
      step();
      InstrD = {tbl_cond[i], 2'b10, 6'b100000, 8'h00};
      ALUFlagsE = tbl_flags[i];
      step();
      ALUFlagsE = 4'b0000;
      check($sformatf("cond_%0d", i), BranchTakenE, tbl_taken[i]);
    end

    // ANDS updates N,Z only; C from the earlier ADDS survives.
    InstrD = I_ADDS;
    step();
    InstrD = I_ANDS; ALUFlagsE = 4'b0010;
    step();
    InstrD = I_BCS; ALUFlagsE = 4'b0100;
    step();
    InstrD = I_BEQ; ALUFlagsE = 4'b0000;
    check("ands_c_kept", BranchTakenE, 1'b1);
    step();
    InstrD = I_NOP;
    check("ands_z_set", BranchTakenE, 1'b1);

    // Asynchronous reset mid-stream.
    InstrD = I_LDR;
    step();
    InstrD = I_STR;
    step();
    InstrD = I_NOP;
    check("pre_reset_regw_m", RegWriteM, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("reset_async", 16'(regd_outs()), 16'h0);
    step();
    reset = 1'b1;
    InstrD = I_BEQ;
    step();
    InstrD = I_ADD;
    check("post_reset_flags", BranchTakenE, 1'b0);
    step();
    InstrD = I_NOP;
    step();
    check("post_reset_add_m", RegWriteM, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

- Control unit for the 5-stage pipelined ARM core. Sits directly upstream of the datapath.
- Decodes the Decode-stage instruction into control signals and carries them through Execute, Memory and Writeback pipeline registers.
- Holds the NZCV flags register and evaluates the condition field in Execute.
- Supplies the hazard unit with the writeback/pending-PC-write status it needs.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; every register updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all pipeline registers and flags
- InstrD  in  20  bits [31:12] of the Decode instruction (cond, op, funct, Rd)
- ALUFlagsE  in  4  NZCV from the datapath ALU, Execute stage
- FlushE  in  1  synchronous clear of the Execute control register (bubble)
- RegSrcD  out  2  register-source select, combinational from InstrD
- ImmSrcD  out  2  immediate-extend select, combinational from InstrD
- ALUSrcE  out  1  ALU B source select: 1 selects the immediate
- ALUControlE  out  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 ORR
- BranchTakenE  out  1  Branch & CondExE
- MemtoRegE  out  1  load in Execute, for load-use stall detection
- RegWriteM  out  1  qualified register write, Memory stage
- MemWriteM  out  1  qualified memory write, Memory stage
- RegWriteW  out  1  qualified register write, Writeback stage
- MemtoRegW  out  1  result select in Writeback
- PCSrcW  out  1  qualified PC write in Writeback
- PCWrPendingF  out  1  PCSrcD | PCSrcE | PCSrcM; the hazard unit uses it to stall Fetch

## Operation
Decode by op = InstrD[27:26]:
- **00, data-processing**
  - RegSrc=00, ImmSrc=00, ALUSrc=funct[5], RegW=1, MemW=0, MemtoReg=0.
  - ALUControl from cmd = funct[4:1]: 0100→00, 0010→01, 0000→10, 1100→11.
  - Any other cmd: RegW=0, FlagW=00.
- **01, memory**
  - ImmSrc=01, ALUSrc=1, ALUControl=00.
  - funct[0]=0 (STR): RegSrc=10, MemW=1, RegW=0.
  - funct[0]=1 (LDR): RegSrc=00, MemtoReg=1, RegW=1.
- **10, branch**
  - RegSrc=01, ImmSrc=10, ALUSrc=1, ALUControl=00, Branch=1, RegW=0.
- **11**
  - All writes 0.

Flag-write and PC-write rules:
- FlagW[1] = S (funct[0]) for data-processing only.
- FlagW[0] = S & (ADD | SUB).
- PCSrcD = (Rd==15 & RegW) | Branch.

Execute-stage condition check, CondExE:
- EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
- HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
- AL 1; cond 1111 → 0.

Qualification in Execute:
- RegWrite, MemWrite and PCSrc are each ANDed with CondExE before entering the Memory register.
- Flags:
  - N,Z are loaded from ALUFlagsE when FlagWE[1] & CondExE.
  - C,V are loaded from ALUFlagsE when FlagWE[0] & CondExE.

## Timing
- Latency: an instruction whose controls are decoded (combinationally) from InstrD in cycle n has its Execute outputs in cycle n+1, its Memory outputs in n+2 and its Writeback outputs in n+3.
- The flags register updates at the end of Execute. An instruction directly following a flag-setting instruction sees the updated flags in its own Execute cycle, with no stall.
- FlushE=1 loads an all-zero bubble into the Execute register on that edge. The Memory and Writeback registers advance normally.
- The controller has no stall input. Decode stalls are realised by the datapath holding InstrD.
- Reset:
  - Asynchronous assertion forces all E/M/W registers and the NZCV register to 0.
  - Every registered output reads 0, including PCWrPendingF's registered terms.
  - In-flight instructions are discarded.
  - The first instruction in Decode after reset deasserts proceeds normally.

## Configuration
- Macro CTRL_CMP_EN.
- Defined: cmd 1010 with S=1 decodes as CMP, with ALUControl=01, RegW=0 and FlagW=11. cmd 1010 with S=0 writes nothing.
- Undefined: cmd 1010 is an unsupported command, with RegW=0, MemW=0 and FlagW=00.

## Structure
- Shared package ctrl_pkg holds:
  - op encodings;
  - ALUControl encodings;
  - cmd encodings;
  - the 4-bit cond encodings.
- Sub-module cond_check: combinational; inputs cond[3:0] and flags[3:0]; output CondEx.

## Test plan
- ADDS r1,r2,r3 with ALUFlagsE=0100, then BEQ → BranchTakenE=1 in the BEQ's Execute cycle.
- LDR r4,[r5,#8] → ImmSrcD=01, MemtoRegE=1 at n+1, RegWriteW=1 and MemtoRegW=1 at n+3.
- STR under NE with Z=1 → MemWriteM=0 and no flag change.
- ADD pc,pc,#4 → PCWrPendingF=1 for cycles n through n+2, and PCSrcW=1 at n+3.
- FlushE=1 with an ADDS in Decode → no RegWriteM, flags unchanged.
- CMP r1,r2 with ALUFlagsE=0110 → flags=0110 and RegWriteM=0 with CTRL_CMP_EN; flags unchanged without it.
- Reset asserted mid-stream → all outputs 0 immediately, without waiting for a clock edge.
